// File: rtl/button_sequence_capture_pkg.sv
// Shared game constants: level encodings, press targets and capture FSM states.
// The comparator and playback stage import the same level constants.
package button_sequence_capture_pkg;

  localparam logic [2:0] LV1 = 3'b001;
  localparam logic [2:0] LV2 = 3'b010;
  localparam logic [2:0] LV3 = 3'b100;

  localparam logic [4:0] TARGET_LV1 = 5'd8;
  localparam logic [4:0] TARGET_LV2 = 5'd12;
  localparam logic [4:0] TARGET_LV3 = 5'd16;

  localparam int IDX_W   = 3;
  localparam int NUM_BTN = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_CAPTURE,
    ST_DONE
  } capture_state_t;

  function automatic logic [4:0] level_target(input logic [2:0] level);
    case (level)
      LV1:     level_target = TARGET_LV1;
      LV2:     level_target = TARGET_LV2;
      LV3:     level_target = TARGET_LV3;
      default: level_target = 5'd0;
    endcase
  endfunction

  // Lowest set bit wins when several buttons settle in the same cycle.
  function automatic logic [IDX_W-1:0] lowest_index(input logic [NUM_BTN-1:0] bits);
    lowest_index = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (bits[i]) lowest_index = IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/button_sequence_capture_debounce.sv
// Single-button debouncer: 2-flop synchroniser followed by a stability counter
// that must see DEBOUNCE_CYCLES consecutive differing samples before db moves.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Counter restarts whenever the input agrees with db, so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      db    <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/button_sequence_capture.sv
// Captures one round of player presses as an ordered list of button indices,
// stopping once the latched level's press target is reached.
module button_sequence_capture #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int SLOTS           = 16,
  parameter int IDX_W           = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       clear,
  input  logic [2:0]                 level,
  input  logic [7:0]                 btn,
  output logic [SLOTS*IDX_W-1:0]     seq_flat,
  output logic [$clog2(SLOTS+1)-1:0] count,
  output logic [7:0]                 press_led,
  output logic                       done
);

  import button_sequence_capture_pkg::*;

  localparam int SLOT_W = $clog2(SLOTS);
  localparam int CNT_W  = $clog2(SLOTS + 1);

  capture_state_t   state;
  logic [7:0]       db;
  logic [7:0]       db_prev;
  logic [7:0]       rise;
  logic [IDX_W-1:0] slots [SLOTS];
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] count_next;
  logic             level_ok;

  for (genvar i = 0; i < 8; i++) begin : g_db
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk(clk),
      .rst(rst),
      .raw(btn[i]),
      .db (db[i])
    );
  end

  assign press_led  = db;
  assign rise       = db & ~db_prev;
  assign count_next = count + CNT_W'(1);
  assign level_ok   = (level == LV1) || (level == LV2) || (level == LV3);

  always_comb begin
    seq_flat = '0;
    for (int k = 0; k < SLOTS; k++) begin
      seq_flat[k*IDX_W +: IDX_W] = slots[k];
    end
  end

  // Round FSM; clear outranks everything, including a press in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      target  <= '0;
      count   <= '0;
      done    <= 1'b0;
      db_prev <= '0;
      slots   <= '{default: '0};
    end else begin
      db_prev <= db;
      if (clear) begin
        state <= ST_IDLE;
        count <= '0;
        done  <= 1'b0;
        slots <= '{default: '0};
      end else begin
        case (state)
          ST_IDLE: begin
            if (enable && level_ok) begin
              target <= CNT_W'(level_target(level));
              state  <= ST_ARM;
            end
          end
          ST_ARM: begin
            if (!enable) begin
              state <= ST_IDLE;
              count <= '0;
              slots <= '{default: '0};
            end else if (db == '0) begin
              state <= ST_CAPTURE;
            end
          end
          ST_CAPTURE: begin
            if (!enable) begin
              state <= ST_IDLE;
              count <= '0;
              slots <= '{default: '0};
            end else if (|rise) begin
              slots[count[SLOT_W-1:0]] <= IDX_W'(lowest_index(rise));
              count <= count_next;
              if (count_next == target) begin
                done  <= 1'b1;
                state <= ST_DONE;
              end
            end
          end
          ST_DONE: begin
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_sequence_capture.sv
// Self-checking bench for button_sequence_capture: each press pushes its expected
// index to a queue, and a monitor pops and checks it whenever count advances.
module tb_button_sequence_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        clear;
  logic [2:0]  level;
  logic [7:0]  btn;
  logic [47:0] seq_flat;
  logic [4:0]  count;
  logic [7:0]  press_led;
  logic        done;

  int          errors = 0;
  int          checks = 0;
  logic [2:0]  exp_q [$];
  logic [2:0]  exp_idx;
  int          exp_target = 8;
  int          prev_count = 0;

  button_sequence_capture #(
    .DEBOUNCE_CYCLES(4),
    .SLOTS          (16),
    .IDX_W          (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .clear    (clear),
    .level    (level),
    .btn      (btn),
    .seq_flat (seq_flat),
    .count    (count),
    .press_led(press_led),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Scoreboard side: every count increment must match the oldest queued press.
  always @(negedge clk) begin
    if (rst) begin
      prev_count = 0;
    end else begin
      if (int'(count) == prev_count + 1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_event: count=%0d slot=%0d with no press expected",
                   count, seq_flat[prev_count*3 +: 3]);
        end else begin
          exp_idx = exp_q.pop_front();
          if (seq_flat[prev_count*3 +: 3] !== exp_idx) begin
            errors++;
            $display("[TB] FAIL slot_%0d: got %0d expected %0d",
                     prev_count, seq_flat[prev_count*3 +: 3], exp_idx);
          end
        end
        checks++;
        if (done !== (int'(count) == exp_target)) begin
          errors++;
          $display("[TB] FAIL done_at_write: count=%0d done=%0b target=%0d",
                   count, done, exp_target);
        end
      end else if (int'(count) > prev_count + 1) begin
        checks++;
        errors++;
        $display("[TB] FAIL count_jump: got %0d after %0d", count, prev_count);
      end
      prev_count = int'(count);
    end
  end

  task automatic press(input int idx, input bit record);
    if (record) exp_q.push_back(3'(idx));
    @(posedge clk); #1 btn[idx] = 1'b1;
    repeat (10) @(posedge clk);
    #1 btn[idx] = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
  endtask

  task automatic start_round(input logic [2:0] lv, input int tgt);
    exp_target = tgt;
    @(posedge clk); #1 level = lv; enable = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic stop_round();
    @(posedge clk); #1 enable = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; clear = 1'b0; level = 3'b001; btn = '0;
    #1;
    checks++;
    if ({seq_flat, count, done, press_led} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: seq=%h count=%0d done=%0b led=%h expected all 0",
               seq_flat, count, done, press_led);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_level1();
    logic [2:0]  idx [8] = '{3'd2, 3'd0, 3'd7, 3'd1, 3'd1, 3'd4, 3'd6, 3'd3};
    logic [47:0] exp_flat = '0;
    start_round(3'b001, 8);
    #1 level = 3'b100;
    for (int i = 0; i < 8; i++) begin
      press(int'(idx[i]), 1'b1);
      exp_flat[i*3 +: 3] = idx[i];
    end
    @(negedge clk);
    checks++;
    if (count !== 5'd8 || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lvl1_complete: count=%0d done=%0b expected 8/1", count, done);
    end
    checks++;
    if (seq_flat !== exp_flat) begin
      errors++;
      $display("[TB] FAIL lvl1_seq: got %h expected %h", seq_flat, exp_flat);
    end
    press(5, 1'b0);
    @(negedge clk);
    checks++;
    if (seq_flat !== exp_flat || count !== 5'd8) begin
      errors++;
      $display("[TB] FAIL lvl1_ninth_press: seq=%h count=%0d expected %h/8", seq_flat, count, exp_flat);
    end
    stop_round();
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || count !== 5'd8) begin
      errors++;
      $display("[TB] FAIL done_enable_drop: done=%0b count=%0d expected 1/8", done, count);
    end
    pulse_clear();
    @(negedge clk);
    checks++;
    if ({seq_flat, count, done} !== '0) begin
      errors++;
      $display("[TB] FAIL lvl1_clear: seq=%h count=%0d done=%0b expected 0", seq_flat, count, done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL lvl1_pending: %0d presses never recorded, expected 0", exp_q.size());
    end
  endtask

  task automatic test_bounce();
    start_round(3'b001, 8);
    repeat (2) begin
      @(posedge clk); #1 btn[5] = 1'b1;
      repeat (2) @(posedge clk);
      #1 btn[5] = 1'b0;
      repeat (4) @(posedge clk);
    end
    @(negedge clk);
    checks++;
    if (count !== 5'd0 || press_led !== 8'h00) begin
      errors++;
      $display("[TB] FAIL glitch_reject: count=%0d led=%h expected 0/00", count, press_led);
    end
    exp_q.push_back(3'd5);
    @(posedge clk); #1 btn[5] = 1'b1;
    repeat (10) @(posedge clk);
    #1 btn[5] = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    checks++;
    if (count !== 5'd1 || seq_flat[2:0] !== 3'd5) begin
      errors++;
      $display("[TB] FAIL bounce_press: count=%0d slot0=%0d expected 1/5", count, seq_flat[2:0]);
    end
    stop_round();
    @(negedge clk);
    checks++;
    if (count !== 5'd0 || seq_flat !== '0) begin
      errors++;
      $display("[TB] FAIL bounce_abort: count=%0d seq=%h expected 0", count, seq_flat);
    end
  endtask

  task automatic test_simultaneous();
    start_round(3'b001, 8);
    exp_q.push_back(3'd1);
    @(posedge clk); #1 btn = 8'b0001_0010;
    repeat (10) @(posedge clk);
    #1 btn = 8'h00;
    repeat (8) @(posedge clk);
    press(4, 1'b1);
    @(negedge clk);
    checks++;
    if (count !== 5'd2 || seq_flat[5:0] !== {3'd4, 3'd1}) begin
      errors++;
      $display("[TB] FAIL simultaneous: count=%0d slots1_0=%h expected 2/21", count, seq_flat[5:0]);
    end
    stop_round();
  endtask

  task automatic test_held_at_arm();
    @(posedge clk); #1 btn[6] = 1'b1;
    repeat (10) @(posedge clk);
    exp_target = 8;
    #1 level = 3'b001; enable = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if (count !== 5'd0 || press_led !== 8'h40) begin
      errors++;
      $display("[TB] FAIL held_at_arm: count=%0d led=%h expected 0/40", count, press_led);
    end
    @(posedge clk); #1 btn[6] = 1'b0;
    repeat (10) @(posedge clk);
    press(6, 1'b1);
    @(negedge clk);
    checks++;
    if (count !== 5'd1 || seq_flat[2:0] !== 3'd6) begin
      errors++;
      $display("[TB] FAIL held_repress: count=%0d slot0=%0d expected 1/6", count, seq_flat[2:0]);
    end
    stop_round();
  endtask

  task automatic test_bad_level();
    start_round(3'b011, 8);
    press(2, 1'b0);
    @(negedge clk);
    checks++;
    if (count !== 5'd0 || seq_flat !== '0) begin
      errors++;
      $display("[TB] FAIL bad_level: count=%0d seq=%h expected 0", count, seq_flat);
    end
    stop_round();
  endtask

  task automatic test_abort_clear();
    logic [47:0] exp_flat = '0;
    int          r;
    start_round(3'b100, 16);
    for (int i = 0; i < 5; i++) press(int'($urandom_range(0, 7)), 1'b1);
    @(negedge clk);
    checks++;
    if (count !== 5'd5) begin
      errors++;
      $display("[TB] FAIL abort_partial: count=%0d expected 5", count);
    end
    stop_round();
    @(negedge clk);
    checks++;
    if (count !== 5'd0 || seq_flat !== '0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_drop: count=%0d seq=%h done=%0b expected 0", count, seq_flat, done);
    end
    start_round(3'b100, 16);
    for (int i = 0; i < 16; i++) begin
      r = int'($urandom_range(0, 7));
      press(r, 1'b1);
      exp_flat[i*3 +: 3] = 3'(r);
    end
    @(negedge clk);
    checks++;
    if (count !== 5'd16 || done !== 1'b1 || seq_flat !== exp_flat) begin
      errors++;
      $display("[TB] FAIL lvl3_complete: count=%0d done=%0b seq=%h expected 16/1/%h",
               count, done, seq_flat, exp_flat);
    end
    @(posedge clk); #1 enable = 1'b0;
    pulse_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({seq_flat, count, done} !== '0) begin
      errors++;
      $display("[TB] FAIL clear_done: seq=%h count=%0d done=%0b expected 0", seq_flat, count, done);
    end
  endtask

  task automatic test_reset_midstream();
    start_round(3'b010, 12);
    press(3, 1'b1);
    press(7, 1'b1);
    press(1, 1'b1);
    exp_q.push_back(3'd0);
    @(posedge clk); #1 btn[0] = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if (press_led[0] !== 1'b1 || count !== 5'd4) begin
      errors++;
      $display("[TB] FAIL pre_reset: led0=%0b count=%0d expected 1/4", press_led[0], count);
    end
    @(posedge clk); #2 rst = 1'b1;
    #1;
    checks++;
    if ({seq_flat, count, done, press_led} !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset: seq=%h count=%0d done=%0b led=%h expected all 0",
               seq_flat, count, done, press_led);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; btn = '0; enable = 1'b0;
    repeat (5) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL final_pending: %0d presses never recorded, expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_level1();
    test_bounce();
    test_simultaneous();
    test_held_at_arm();
    test_bad_level();
    test_abort_clear();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
